// File: rtl/sale_terminal_pkg.sv
// Shared types for the sale-terminal keypad front end: FSM states, decoded key events,
// and the KEY bit assigned to each command / navigation function.
package sale_terminal_pkg;

    typedef enum logic [1:0] {
        ST_ENTRY = 2'd0,
        ST_QTY   = 2'd1
    } entry_state_t;

    typedef enum logic [2:0] {
        EV_NONE,
        EV_DIGIT,
        EV_SELECT,
        EV_CLEAR,
        EV_BKSP,
        EV_PREV,
        EV_NEXT,
        EV_CONFIRM
    } key_evt_t;

    localparam int NUM_KEYS = 4;

    localparam logic [1:0] KEY_IDX_PREV    = 2'd3;
    localparam logic [1:0] KEY_IDX_NEXT    = 2'd1;
    localparam logic [1:0] KEY_IDX_CONFIRM = 2'd0;
    localparam logic [1:0] KEY_IDX_SELECT  = 2'd3;
    localparam logic [1:0] KEY_IDX_CLEAR   = 2'd2;
    localparam logic [1:0] KEY_IDX_BKSP    = 2'd1;

    // Digit mode numbers the keys from the left: KEY3=1 ... KEY0=4.
    function automatic logic [3:0] key_digit(input logic [1:0] idx);
        return 4'd4 - {2'b00, idx};
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// One KEY bit: 2-FF synchroniser, optional stability filter (KEYPAD_DEBOUNCE_EN), and a
// one-cycle press pulse on each accepted released->pressed transition.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key_n,
    output logic o_press
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic r_press;
    logic r_ok1;
    logic r_ok2;
    logic r_armed;
    logic w_level;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
        end
    end

`ifdef KEYPAD_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] r_cnt;
    logic          r_stable;

    // Count consecutive samples that disagree with the accepted level; any agreeing
    // sample restarts the count, so short glitches never reach the threshold.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_stable <= 1'b1;
        end else if (r_sync2 == r_stable) begin
            r_cnt <= '0;
        end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            r_cnt    <= '0;
            r_stable <= r_sync2;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_level = r_stable;
`else
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

    assign w_level = r_sync2;
`endif

    // Presses are only honoured once a genuine released level has been seen after reset,
    // so a key held through reset must be let go before it can fire.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ok1   <= 1'b0;
            r_ok2   <= 1'b0;
            r_armed <= 1'b0;
            r_prev  <= 1'b1;
            r_press <= 1'b0;
        end else begin
            r_ok1   <= 1'b1;
            r_ok2   <= r_ok1;
            r_armed <= r_armed | (r_ok2 & r_sync2);
            r_prev  <= w_level;
            r_press <= r_armed & r_prev & ~w_level;
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/keypad_entry_decoder.sv
// Keypad front end: debounces KEY[3:0], decodes them with SW into digits, commands and
// navigation pulses, and assembles a BCD barcode plus quantity. Option: KEYPAD_DEBOUNCE_EN.
module keypad_entry_decoder
    import sale_terminal_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DIGITS          = 4
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET,
    input  logic [3:0]            KEY,
    input  logic [2:0]            SW,
    output logic [4*DIGITS-1:0]   barcode,
    output logic                  barcode_valid,
    output logic [3:0]            quantity,
    output logic                  qty_valid,
    output logic                  nav_prev,
    output logic                  nav_next,
    output logic                  nav_confirm,
    output logic [2:0]            entry_count,
    output logic [1:0]            entry_state
);

    logic [NUM_KEYS-1:0] w_press;
    logic [1:0]          r_sw_meta;
    logic [1:0]          r_sw;
    logic                w_unused_sw2;

    entry_state_t        r_state;
    entry_state_t        w_state_next;
    logic [2:0]          r_count;
    logic [2:0]          w_count_next;
    logic [4*DIGITS-1:0] r_barcode;
    logic [4*DIGITS-1:0] w_barcode_next;
    logic [3:0]          r_quantity;
    logic [3:0]          w_quantity_next;
    logic                r_barcode_valid;
    logic                w_barcode_valid_next;
    logic                r_qty_valid;
    logic                w_qty_valid_next;
    logic                r_nav_prev;
    logic                r_nav_next;
    logic                r_nav_confirm;

    logic                w_any;
    logic [1:0]          w_idx;
    key_evt_t            w_evt;
    logic [3:0]          w_digit;

    assign w_unused_sw2 = SW[2];

    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            key_debouncer #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debouncer (
                .i_clk  (CLOCK_50),
                .i_rst  (RESET),
                .i_key_n(KEY[gi]),
                .o_press(w_press[gi])
            );
        end
    endgenerate

    // Ascending scan: the highest pressed index is the last one written and wins.
    always_comb begin
        w_any = |w_press;
        w_idx = 2'd0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (w_press[i]) w_idx = 2'(i);
        end
    end

    always_comb begin
        w_evt   = EV_NONE;
        w_digit = 4'd0;
        if (w_any) begin
            if (r_sw[1]) begin
                case (w_idx)
                    KEY_IDX_PREV:    w_evt = EV_PREV;
                    KEY_IDX_NEXT:    w_evt = EV_NEXT;
                    KEY_IDX_CONFIRM: w_evt = EV_CONFIRM;
                    default:         w_evt = EV_NONE;
                endcase
            end else if (r_sw[0]) begin
                case (w_idx)
                    KEY_IDX_SELECT: w_evt = EV_SELECT;
                    KEY_IDX_CLEAR:  w_evt = EV_CLEAR;
                    KEY_IDX_BKSP:   w_evt = EV_BKSP;
                    default:        w_evt = EV_NONE;
                endcase
            end else begin
                w_evt   = EV_DIGIT;
                w_digit = key_digit(w_idx);
            end
        end
    end

    always_comb begin
        w_state_next         = r_state;
        w_count_next         = r_count;
        w_barcode_next       = r_barcode;
        w_quantity_next      = r_quantity;
        w_barcode_valid_next = 1'b0;
        w_qty_valid_next     = 1'b0;
        case (r_state)
            ST_ENTRY: begin
                case (w_evt)
                    EV_DIGIT: begin
                        if (r_count < 3'(DIGITS)) begin
                            // First-entered digit occupies the most significant nibble.
                            for (int i = 0; i < DIGITS; i++) begin
                                if (i == DIGITS - 1 - int'(r_count)) w_barcode_next[i*4 +: 4] = w_digit;
                            end
                            w_count_next = r_count + 3'd1;
                        end
                    end
                    EV_BKSP: begin
                        if (r_count != 3'd0) begin
                            for (int i = 0; i < DIGITS; i++) begin
                                if (i == DIGITS - int'(r_count)) w_barcode_next[i*4 +: 4] = 4'd0;
                            end
                            w_count_next = r_count - 3'd1;
                        end
                    end
                    EV_CLEAR: begin
                        w_count_next   = 3'd0;
                        w_barcode_next = '0;
                    end
                    EV_SELECT: begin
                        if (r_count == 3'(DIGITS)) begin
                            w_barcode_valid_next = 1'b1;
                            w_state_next         = ST_QTY;
                        end
                    end
                    default: ;
                endcase
            end
            ST_QTY: begin
                case (w_evt)
                    EV_DIGIT: begin
                        w_quantity_next  = w_digit;
                        w_qty_valid_next = 1'b1;
                        w_state_next     = ST_ENTRY;
                        w_count_next     = 3'd0;
                    end
                    EV_CLEAR: begin
                        w_state_next = ST_ENTRY;
                        w_count_next = 3'd0;
                    end
                    default: ;
                endcase
            end
            default: w_state_next = ST_ENTRY;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_sw_meta       <= 2'b00;
            r_sw            <= 2'b00;
            r_state         <= ST_ENTRY;
            r_count         <= 3'd0;
            r_barcode       <= '0;
            r_quantity      <= 4'd0;
            r_barcode_valid <= 1'b0;
            r_qty_valid     <= 1'b0;
            r_nav_prev      <= 1'b0;
            r_nav_next      <= 1'b0;
            r_nav_confirm   <= 1'b0;
        end else begin
            r_sw_meta       <= SW[1:0];
            r_sw            <= r_sw_meta;
            r_state         <= w_state_next;
            r_count         <= w_count_next;
            r_barcode       <= w_barcode_next;
            r_quantity      <= w_quantity_next;
            r_barcode_valid <= w_barcode_valid_next;
            r_qty_valid     <= w_qty_valid_next;
            r_nav_prev      <= (w_evt == EV_PREV);
            r_nav_next      <= (w_evt == EV_NEXT);
            r_nav_confirm   <= (w_evt == EV_CONFIRM);
        end
    end

    assign barcode       = r_barcode;
    assign barcode_valid = r_barcode_valid;
    assign quantity      = r_quantity;
    assign qty_valid     = r_qty_valid;
    assign nav_prev      = r_nav_prev;
    assign nav_next      = r_nav_next;
    assign nav_confirm   = r_nav_confirm;
    assign entry_count   = r_count;
    assign entry_state   = r_state;

endmodule

// File: tb/tb_keypad_entry_decoder.sv
// Directed bench for keypad_entry_decoder; expectations follow KEYPAD_DEBOUNCE_EN when defined.
module tb_keypad_entry_decoder;

`ifdef KEYPAD_DEBOUNCE_EN
    localparam int LAT = 8;
`else
    localparam int LAT = 4;
`endif

    logic        CLOCK_50 = 1'b0;
    logic        RESET    = 1'b1;
    logic [3:0]  KEY      = 4'hF;
    logic [2:0]  SW       = 3'b000;
    logic [15:0] barcode;
    logic        barcode_valid;
    logic [3:0]  quantity;
    logic        qty_valid;
    logic        nav_prev;
    logic        nav_next;
    logic        nav_confirm;
    logic [2:0]  entry_count;
    logic [1:0]  entry_state;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int press_cyc = 0;
    int last_pulse_cyc = 0;
    int n_bv = 0, n_qv = 0, n_prev = 0, n_next = 0, n_conf = 0, n_multi = 0;

    keypad_entry_decoder #(
        .DEBOUNCE_CYCLES(4),
        .DIGITS         (4)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .RESET        (RESET),
        .KEY          (KEY),
        .SW           (SW),
        .barcode      (barcode),
        .barcode_valid(barcode_valid),
        .quantity     (quantity),
        .qty_valid    (qty_valid),
        .nav_prev     (nav_prev),
        .nav_next     (nav_next),
        .nav_confirm  (nav_confirm),
        .entry_count  (entry_count),
        .entry_state  (entry_state)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // Pulse monitor, sampled on the falling edge: counts every high cycle of each pulse.
    always @(negedge CLOCK_50) begin
        int hi;
        hi = int'(barcode_valid) + int'(qty_valid) + int'(nav_prev) + int'(nav_next) + int'(nav_confirm);
        if (barcode_valid) n_bv++;
        if (qty_valid) n_qv++;
        if (nav_prev) n_prev++;
        if (nav_next) n_next++;
        if (nav_confirm) n_conf++;
        if (hi > 1) n_multi++;
        if (hi > 0) last_pulse_cyc = cyc;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] mask, input int hold);
        @(negedge CLOCK_50);
        KEY = ~mask;
        press_cyc = cyc;
        repeat (hold) @(negedge CLOCK_50);
        KEY = 4'hF;
        repeat (20) @(negedge CLOCK_50);
    endtask

    initial begin
        repeat (3) @(negedge CLOCK_50);
        chk("rst_barcode", 32'(barcode), 32'h0);
        chk("rst_count", 32'(entry_count), 32'd0);
        chk("rst_state", 32'(entry_state), 32'd0);
        chk("rst_qty", 32'(quantity), 32'd0);
        RESET = 1'b0;
        repeat (5) @(negedge CLOCK_50);

        // 1: digits 1,2,1,3 (SW[2] set on the first one is ignored), then SELECT
        SW = 3'b100;
        press(4'b1000, 10);
        chk("t1_count1", 32'(entry_count), 32'd1);
        SW = 3'b000;
        press(4'b0100, 10);
        press(4'b1000, 10);
        press(4'b0010, 10);
        chk("t1_count4", 32'(entry_count), 32'd4);
        chk("t1_barcode", 32'(barcode), 32'h1213);
        chk("t1_no_bv_yet", 32'(n_bv), 32'd0);
        SW = 3'b001;
        press(4'b1000, 10);
        chk("t1_bv_once", 32'(n_bv), 32'd1);
        chk("t1_state_qty", 32'(entry_state), 32'd1);
        chk("t1_barcode_held", 32'(barcode), 32'h1213);

        // 2: quantity digit 3
        SW = 3'b000;
        press(4'b0010, 10);
        chk("t2_qty", 32'(quantity), 32'd3);
        chk("t2_qv_once", 32'(n_qv), 32'd1);
        chk("t2_state", 32'(entry_state), 32'd0);
        chk("t2_count", 32'(entry_count), 32'd0);
        chk("t2_barcode", 32'(barcode), 32'h1213);

        // 3: navigation
        SW = 3'b010;
        press(4'b0010, 10);
        chk("t3_next_once", 32'(n_next), 32'd1);
        chk("t3_latency", 32'(last_pulse_cyc - press_cyc), 32'(LAT));
        press(4'b0001, 10);
        chk("t3_confirm_once", 32'(n_conf), 32'd1);
        press(4'b0100, 10);
        chk("t3_key2_ignored", 32'(n_prev + n_next + n_conf), 32'd2);
        chk("t3_barcode", 32'(barcode), 32'h1213);
        chk("t3_count", 32'(entry_count), 32'd0);
        chk("t3_state", 32'(entry_state), 32'd0);
        chk("t3_bv_qv", 32'(n_bv + n_qv), 32'd2);

        // 4: short SELECT, 5th digit dropped, BACKSPACE, CLEAR
        SW = 3'b000;
        press(4'b1000, 10);
        press(4'b0100, 10);
        press(4'b0010, 10);
        chk("t4_count3", 32'(entry_count), 32'd3);
        SW = 3'b001;
        press(4'b1000, 10);
        chk("t4_short_select", 32'(n_bv), 32'd1);
        chk("t4_state_entry", 32'(entry_state), 32'd0);
        SW = 3'b000;
        press(4'b0001, 10);
        press(4'b1000, 10);
        chk("t4_count_full", 32'(entry_count), 32'd4);
        chk("t4_barcode", 32'(barcode), 32'h1234);
        SW = 3'b001;
        press(4'b0010, 10);
        chk("t4_bksp_barcode", 32'(barcode), 32'h1230);
        chk("t4_bksp_count", 32'(entry_count), 32'd3);
        press(4'b0100, 10);
        chk("t4_clear_barcode", 32'(barcode), 32'h0);
        chk("t4_clear_count", 32'(entry_count), 32'd0);

        // 5: simultaneous KEY3+KEY0, then reset mid-entry with a key held through it
        SW = 3'b000;
        press(4'b1001, 10);
        chk("t5_simul_count", 32'(entry_count), 32'd1);
        chk("t5_simul_barcode", 32'(barcode), 32'h1000);
        press(4'b0100, 10);
        chk("t5_two_digits", 32'(barcode), 32'h1200);
        @(negedge CLOCK_50);
        RESET = 1'b1;
        KEY = 4'b0111;
        #1;
        chk("t5_rst_barcode", 32'(barcode), 32'h0);
        chk("t5_rst_count", 32'(entry_count), 32'd0);
        chk("t5_rst_qty", 32'(quantity), 32'd0);
        repeat (5) @(negedge CLOCK_50);
        RESET = 1'b0;
        repeat (15) @(negedge CLOCK_50);
        KEY = 4'hF;
        repeat (20) @(negedge CLOCK_50);
        chk("t5_held_no_event", 32'(entry_count), 32'd0);
        press(4'b1000, 10);
        chk("t5_after_release", 32'(barcode), 32'h1000);

        // 6: 2-cycle glitch, then 5-cycle hold on KEY2
        press(4'b0100, 2);
`ifdef KEYPAD_DEBOUNCE_EN
        chk("t6_glitch", 32'(entry_count), 32'd1);
        press(4'b0100, 5);
        chk("t6_hold_count", 32'(entry_count), 32'd2);
        chk("t6_hold_barcode", 32'(barcode), 32'h1200);
`else
        chk("t6_glitch", 32'(entry_count), 32'd2);
        press(4'b0100, 5);
        chk("t6_hold_count", 32'(entry_count), 32'd3);
        chk("t6_hold_barcode", 32'(barcode), 32'h1220);
`endif

        chk("one_pulse_per_cycle", 32'(n_multi), 32'd0);
        chk("prev_never", 32'(n_prev), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
